mac_relu_unit: RTL and testbench

- Pipelined signed multiply-accumulate datapath with a built-in ReLU output.
- The convolution engine feeds it one pixel/weight pair per cycle (9 pairs per 3x3 window).
- It then waits for the pipeline to drain and reads the rectified accumulator to write into output RAM.
- One instance per compute core; purely datapath, no memory access.

---
 rtl/mac_relu_unit.sv | 91 +++++++++
 tb/tb_mac_relu_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mac_relu_unit.sv
// mac_relu_unit: two-stage pipelined signed multiply-accumulate with a ReLU view
// of the accumulator. Optional build macro MAC_SAT_EN switches the accumulator
// from two's-complement wrap to saturation on out-of-range sums.
module mac_relu_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              enable,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  relu_acc,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
    localparam int unsigned TOP_W  = SUM_W - ACC_W + 1;

    logic signed [DATA_W-1:0] a_q;
    logic signed [DATA_W-1:0] b_q;
    logic                     v1_q;
    logic signed [PROD_W-1:0] prod_q;
    logic                     v2_q;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic [TOP_W-1:0]         sum_top_c;
    logic                     out_of_range_c;
    logic [ACC_W-1:0]         acc_next_c;

    // Full-width signed product of the stage-1 operands
    assign prod_c = PROD_W'(a_q) * PROD_W'(b_q);

    // Exact sum; it fits ACC_W bits only if all bits from ACC_W-1 upward agree
    assign sum_c          = SUM_W'(prod_q) + SUM_W'($signed(acc));
    assign sum_top_c      = sum_c[SUM_W-1:ACC_W-1];
    assign out_of_range_c = !((&sum_top_c) || !(|sum_top_c));

    // Narrow the exact sum back to the accumulator width
    always_comb begin
        acc_next_c = sum_c[ACC_W-1:0];
`ifdef MAC_SAT_EN
        if (out_of_range_c) begin
            acc_next_c = sum_c[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    // Operand capture, product stage and accumulate, with reset/clear priority
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            v1_q     <= 1'b0;
            prod_q   <= '0;
            v2_q     <= 1'b0;
            acc      <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            v1_q <= enable;
            if (enable) begin
                a_q <= a;
                b_q <= b;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                prod_q <= prod_c;
            end
            if (v2_q) begin
                acc      <= acc_next_c;
                overflow <= overflow | out_of_range_c;
            end
        end
    end

    // Rectified view and in-flight indication derived from registered state
    assign relu_acc = acc[ACC_W-1] ? '0 : acc;
    assign busy     = v1_q | v2_q;

endmodule

// File: tb/tb_mac_relu_unit.sv
// Directed bench for mac_relu_unit; define MAC_SAT_EN to check the saturating build.
module tb_mac_relu_unit;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        enable;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;
    logic [31:0] relu_acc;
    logic        busy;
    logic        overflow;

    int checks;
    int errors;
    logic signed [31:0] wv [9];

    mac_relu_unit #(.DATA_W(32), .ACC_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .enable   (enable),
        .a        (a),
        .b        (b),
        .acc      (acc),
        .relu_acc (relu_acc),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c, input logic e, input logic [31:0] av, input logic [31:0] bv);
        clr    = c;
        enable = e;
        a      = av;
        b      = bv;
    endtask

    // Clear, then feed pixels 10..18 against the weights in wv, then drain two cycles
    task automatic run_window();
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, 32'(10 + i), wv[i]);
            tick();
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        chk("window_busy_last", 32'(busy), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(1'b0, 1'b1, 32'd5, 32'd7);

        // Reset holds everything at zero even with enable high
        tick();
        tick();
        chk("rst_acc", acc, 32'd0);
        chk("rst_relu", relu_acc, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("rst_release_acc", acc, 32'd0);
        chk("rst_release_busy", 32'(busy), 32'd0);

        // Positive window: -(10+11+12) + (16+17+18) = 18
        wv = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
        run_window();
        chk("pos_acc", acc, 32'd18);
        chk("pos_relu", relu_acc, 32'd18);
        chk("pos_busy", 32'(busy), 32'd0);

        // Negative window: -18
        wv = '{1, 1, 1, 0, 0, 0, -1, -1, -1};
        run_window();
        chk("neg_acc", acc, 32'hFFFF_FFEE);
        chk("neg_relu", relu_acc, 32'd0);
        chk("neg_ovf", 32'(overflow), 32'd0);

        // Latency: single pair 3*4 visible two edges after sampling
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'd3, 32'd4);
        tick();
        chk("lat_k_acc", acc, 32'd0);
        chk("lat_k_busy", 32'(busy), 32'd1);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("lat_k1_acc", acc, 32'd0);
        chk("lat_k1_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_k2_acc", acc, 32'd12);
        chk("lat_k2_relu", relu_acc, 32'd12);
        chk("lat_k2_busy", 32'(busy), 32'd0);

        // Clear one edge after an operand pair discards it
        drive(1'b0, 1'b1, 32'd100, 32'd100);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        chk("clr_k1_acc", acc, 32'd0);
        chk("clr_k1_busy", 32'(busy), 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("clr_k2_acc", acc, 32'd0);
        tick();
        chk("clr_k3_acc", acc, 32'd0);

        // clr beats enable in the same cycle
        drive(1'b1, 1'b1, 32'd9, 32'd9);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        tick();
        chk("clr_beats_en_acc", acc, 32'd0);

        // Positive overflow: 2^31 then 2^31 again
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'h4000_0000, 32'd2);
        tick();
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("povf1_ovf", 32'(overflow), 32'd1);
`ifdef MAC_SAT_EN
        chk("povf1_acc", acc, 32'h7FFF_FFFF);
        chk("povf1_relu", relu_acc, 32'h7FFF_FFFF);
`else
        chk("povf1_acc", acc, 32'h8000_0000);
        chk("povf1_relu", relu_acc, 32'd0);
`endif
        tick();
        chk("povf2_ovf", 32'(overflow), 32'd1);
`ifdef MAC_SAT_EN
        chk("povf2_acc", acc, 32'h7FFF_FFFF);
        chk("povf2_relu", relu_acc, 32'h7FFF_FFFF);
`else
        chk("povf2_acc", acc, 32'd0);
        chk("povf2_relu", relu_acc, 32'd0);
`endif

        // clr drops the sticky flag
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        chk("ovf_clr", 32'(overflow), 32'd0);
        chk("ovf_clr_acc", acc, 32'd0);

        // Negative boundary: -2^31 fits, a second -2^31 does not
        drive(1'b0, 1'b1, 32'hC000_0000, 32'd2);
        tick();
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("novf1_acc", acc, 32'h8000_0000);
        chk("novf1_ovf", 32'(overflow), 32'd0);
        chk("novf1_relu", relu_acc, 32'd0);
        tick();
        chk("novf2_ovf", 32'(overflow), 32'd1);
`ifdef MAC_SAT_EN
        chk("novf2_acc", acc, 32'h8000_0000);
`else
        chk("novf2_acc", acc, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
